// File: rtl/counter_mod6_if.sv
// rtl/counter_mod6_if.sv - count-enable / count / carry bundle for one counter_mod6 stage.
// LD and D exist only when COUNTER_MOD6_LOAD_EN is defined.
interface counter_mod6_if #(
  parameter int WIDTH = 4
) ();
  logic             EN;
  logic [WIDTH-1:0] Q;
  logic             CO;
`ifdef COUNTER_MOD6_LOAD_EN
  logic             LD;
  logic [WIDTH-1:0] D;
`endif

`ifdef COUNTER_MOD6_LOAD_EN
  modport master (output EN, output LD, output D, input Q, input CO);
  modport slave  (input EN, input LD, input D, output Q, output CO);
`else
  modport master (output EN, input Q, input CO);
  modport slave  (input EN, output Q, output CO);
`endif
endinterface

// File: rtl/counter_mod6.sv
// rtl/counter_mod6.sv - modulo-MODULUS up-counter with enable, carry-out and async clear.
// Optional synchronous load (time-setting) under macro COUNTER_MOD6_LOAD_EN.
module counter_mod6 #(
  parameter int MODULUS = 6,
  parameter int WIDTH   = 4
) (
  input  logic         CP,
  input  logic         nCR,
  counter_mod6_if.slave bus
);
  localparam logic [WIDTH-1:0] LAST  = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH:0]   MOD_W = (WIDTH + 1)'(MODULUS);

  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] q_d;
  logic             at_last;
  logic             ld;
  logic [WIDTH-1:0] ld_val;

`ifdef COUNTER_MOD6_LOAD_EN
  assign ld     = bus.LD;
  // Out-of-range load values are mapped to 0 so the counter never enters an illegal state by load.
  assign ld_val = ({1'b0, bus.D} < MOD_W) ? bus.D : '0;
`else
  assign ld     = 1'b0;
  assign ld_val = '0;
`endif

  assign at_last = (q_q == LAST);

  // Anything at or above LAST, including upset values, restarts at 0 when enabled.
  always_comb begin
    q_d = q_q;
    if (ld) begin
      q_d = ld_val;
    end else if (bus.EN) begin
      q_d = (q_q < LAST) ? q_q + WIDTH'(1) : '0;
    end
  end

  always_ff @(posedge CP or negedge nCR) begin
    if (!nCR) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign bus.Q  = q_q;
  assign bus.CO = bus.EN & at_last & ~ld;
endmodule

// File: tb/tb_counter_mod6.sv
// tb/tb_counter_mod6.sv - directed self-checking bench for counter_mod6.
// Load vectors are applied only when COUNTER_MOD6_LOAD_EN is defined.
module tb_counter_mod6;
  logic CP;
  logic nCR;
  int   vectors;
  int   miscompares;

  counter_mod6_if #(.WIDTH(4)) bus ();

  counter_mod6 #(.MODULUS(6), .WIDTH(4)) dut (
    .CP  (CP),
    .nCR (nCR),
    .bus (bus)
  );

  initial CP = 1'b0;
  always #5 CP = ~CP;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CP);
    #1;
  endtask

  initial begin
    int exp_seq [7];
    exp_seq = '{1, 2, 3, 4, 5, 0, 1};
    vectors = 0;
    miscompares = 0;
    nCR    = 1'b0;
    bus.EN = 1'b0;
`ifdef COUNTER_MOD6_LOAD_EN
    bus.LD = 1'b0;
    bus.D  = '0;
`endif

    #1;
    chk("reset_q", 32'(bus.Q), 0);
    chk("reset_co", 32'(bus.CO), 0);
    tick();
    chk("reset_edge_q", 32'(bus.Q), 0);
    chk("reset_edge_co", 32'(bus.CO), 0);

    @(negedge CP);
    nCR    = 1'b1;
    bus.EN = 1'b1;
    for (int i = 0; i < 7; i++) begin
      tick();
      chk($sformatf("count_q[%0d]", i), 32'(bus.Q), 32'(exp_seq[i]));
      chk($sformatf("count_co[%0d]", i), 32'(bus.CO), (exp_seq[i] == 5) ? 1 : 0);
    end

    tick();
    tick();
    chk("pre_hold_q", 32'(bus.Q), 3);
    bus.EN = 1'b0;
    #1;
    chk("hold_co", 32'(bus.CO), 0);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk($sformatf("hold_q[%0d]", i), 32'(bus.Q), 3);
      chk($sformatf("hold_co[%0d]", i), 32'(bus.CO), 0);
    end
    bus.EN = 1'b1;
    tick();
    chk("resume_q", 32'(bus.Q), 4);
    chk("resume_co", 32'(bus.CO), 0);

    #2;
    nCR = 1'b0;
    #1;
    chk("async_clr_q", 32'(bus.Q), 0);
    chk("async_clr_co", 32'(bus.CO), 0);
    tick();
    chk("clr_hold_q0", 32'(bus.Q), 0);
    tick();
    chk("clr_hold_q1", 32'(bus.Q), 0);
    nCR = 1'b1;
    tick();
    chk("release_q", 32'(bus.Q), 1);

    for (int i = 2; i <= 5; i++) begin
      tick();
      chk($sformatf("recount_q[%0d]", i), 32'(bus.Q), 32'(i));
    end
    chk("recount_co5", 32'(bus.CO), 1);

    force dut.q_q = 4'd9;
    #1;
    chk("illegal_q", 32'(bus.Q), 9);
    chk("illegal_co", 32'(bus.CO), 0);
    release dut.q_q;
    tick();
    chk("illegal_recover_q", 32'(bus.Q), 0);
    tick();
    chk("illegal_after_q", 32'(bus.Q), 1);

`ifdef COUNTER_MOD6_LOAD_EN
    bus.EN = 1'b0;
    bus.LD = 1'b1;
    bus.D  = 4'd4;
    tick();
    chk("load4_q", 32'(bus.Q), 4);
    bus.D  = 4'd7;
    tick();
    chk("load7_q", 32'(bus.Q), 0);
    bus.EN = 1'b1;
    bus.D  = 4'd2;
    tick();
    chk("load_over_en_q", 32'(bus.Q), 2);
    bus.D  = 4'd5;
    tick();
    chk("load5_q", 32'(bus.Q), 5);
    chk("load_co_masked", 32'(bus.CO), 0);
    bus.LD = 1'b0;
    #1;
    chk("unload_co", 32'(bus.CO), 1);
    tick();
    chk("unload_wrap_q", 32'(bus.Q), 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
